mux_41_rr_arbiter: RTL and testbench
====================================

Name: mux_41_rr_arbiter

Overview:
- Round-robin packet arbiter that shares one 4:1 data mux between four requesters.
- Each requester holds the mux for a whole packet; the grant is released after the beat flagged last is accepted.
- Drives a registered output stage with valid/ready backpressure.
- Sits in front of any single-consumer resource fed by four sources.

Parameters:
- WIDTH, 8, data width per channel and of the output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  per-channel beat valid; a high bit is also that channel's request.
- in_last  input  4  per-channel last-beat-of-packet flag, qualified by in_valid.
- in_data  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  4  per-channel accept; at most one bit high.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered muxed data.
- out_last  output  1  registered last flag.
- out_ready  input  1  consumer accepts the output beat.
- grant  output  4  one-hot owner of the mux; all zero when idle.
- sel  output  2  encoded owner; it is the mux select and holds its last value when idle.
- busy  output  1  high in state BUSY.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0; state IDLE; priority pointer ptr = 0.
- The reset takes effect immediately, including mid-packet. The current packet is dropped with no completion.
- States: IDLE and BUSY.
- IDLE, with in_valid == 0: stay in IDLE.
- IDLE, with any in_valid bit high, winner selection:
  - The winner is the first set bit searching ptr, ptr+1, ... modulo 4.
  - At the next edge: state becomes BUSY, grant is set to onehot(winner), sel becomes winner, busy goes to 1.
  - Arbitration latency is 1 cycle. in_ready is all 0 while in IDLE.
- BUSY, acceptance:
  - Define can_load = !out_valid || out_ready.
  - in_ready[sel] = can_load; every other in_ready bit is 0. The ready path is combinational from out_valid, out_ready and state.
  - A beat is accepted when in_valid[sel] && in_ready[sel].
  - On an accepted beat, at the next edge: out_data = in_data[sel], out_last = in_last[sel], out_valid = 1.
- BUSY, output register hold and drain:
  - Without a new accepted beat, if out_valid && out_ready then out_valid goes to 0.
  - Otherwise out_valid, out_data and out_last hold.
  - Load and drain in the same cycle gives back-to-back beats at full throughput (one beat per cycle).
- BUSY, release:
  - When the accepted beat has in_last[sel] = 1: at the same edge, state becomes IDLE, grant = 0, busy = 0 and ptr = (sel+1) mod 4.
  - The output register may still hold that last beat; it drains independently of the state.
  - At least one IDLE cycle always follows a packet. The next grant comes 2 edges after the last beat is accepted.
- BUSY, granted channel drops in_valid mid-packet: the grant is held indefinitely; there is no timeout and no preemption.
- Other channels' requests during BUSY are ignored. They do not need to hold their request for correctness; they are sampled only in IDLE.
- A single-beat packet (in_valid with in_last high) gives BUSY for 1 cycle.
- The pointer advances only on packet completion, never on grant. A sole requester wins repeatedly.
- Fairness: with all 4 requesting continuously, grants rotate 0,1,2,3,0,...
- out_data and out_last are don't-care when out_valid = 0, but they retain their last value (no X).

Test Plan:
- Single requester, WIDTH=8: ch2 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33), out_ready=1 -> grant=0100 and sel=2 one edge after the request. out_data gives 0x11, 0x22, 0x33 on consecutive cycles with out_last only on 0x33. Then IDLE and ptr=3.
- All four channels send continuous 1-beat packets from reset -> grant order 0001, 0010, 0100, 1000, 0001. Each grant is separated by one IDLE cycle. in_data of channel i = 0xA0+i appears in that order on out_data.
- Backpressure: ch0 sends a 4-beat packet while out_ready is held 0 for 3 cycles after the first beat -> in_ready[0]=0 while out_valid=1. out_data holds 0x?? stable with no beat lost or duplicated. All 4 beats arrive once out_ready=1.
- Pointer wrap: ch3 completes a packet while ch0 and ch3 both request -> the next winner is ch0 (ptr=0), not ch3.
- Reset mid-packet: assert rst_n=0 asynchronously between edges in beat 2 of a ch1 packet -> grant, sel, busy, out_valid and in_ready go to 0 immediately. After release with ch1 and ch2 requesting, ch0 priority restarts and ch1 wins.
- Stalled owner: ch1 is granted, then in_valid[1] drops for 5 cycles while ch3 requests -> grant stays 0010 and in_ready[3]=0. The packet resumes and completes, then ch3 is granted.

Source files
------------

// File: rtl/mux_41_rr_arbiter.sv
// Round-robin packet arbiter: four requesters share one 4:1 data mux, each holding it
// for a whole packet, feeding a registered valid/ready output stage.
module mux_41_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [3:0]         in_last,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [3:0]         grant,
  output logic [1:0]         sel,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       sel_reg, sel_next;
  logic [WIDTH-1:0] chan_data [4];
  logic [1:0]       winner;
  logic             found;
  logic             can_load;
  logic             accept;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign grant[gi]     = (state_reg == BUSY) && (sel_reg == 2'(gi));
      assign in_ready[gi]  = (state_reg == BUSY) && (sel_reg == 2'(gi)) && can_load;
    end
  endgenerate

  assign busy     = (state_reg == BUSY);
  assign sel      = sel_reg;
  assign can_load = !out_valid || out_ready;
  assign accept   = (state_reg == BUSY) && in_valid[sel_reg] && can_load;

  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    winner = ptr_reg;
    found  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[ptr_reg + 2'(k)]) begin
        winner = ptr_reg + 2'(k);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = BUSY;
          sel_next   = winner;
        end
      end
      BUSY: begin
        if (accept && in_last[sel_reg]) begin
          state_next = IDLE;
          ptr_next   = sel_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd0;
      sel_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
    end
  end

  // The output register drains on its own, even after the owner has released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= chan_data[sel_reg];
      out_last  <= in_last[sel_reg];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_41_rr_arbiter.sv
// Bench for mux_41_rr_arbiter: per-channel packet queues drive the inputs and a
// behavioural model (owner index, pointer, output slot) predicts every cycle.
module tb_mux_41_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        busy;

  mux_41_rr_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant(grant), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Beat = {last, data}
  logic [8:0] pq [4][$];
  logic [8:0] got [$];
  logic [3:0] gq [$];
  logic [3:0] stall;
  int n_checks = 0;
  int n_pass = 0;

  // Reference model state: owner -1 means nobody holds the mux.
  int         m_owner;
  int         m_ptr;
  int         m_sel;
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_ol;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_sel = 0; m_ov = 0; m_od = 8'h00; m_ol = 0;
  endfunction

  function automatic logic [3:0] exp_grant();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  function automatic logic [3:0] exp_ready();
    if (m_owner >= 0 && (!m_ov || out_ready)) return 4'(1 << m_owner);
    return 4'b0000;
  endfunction

  function automatic void model_edge();
    bit can_take;
    int win;
    can_take = !m_ov || out_ready;
    if (m_owner >= 0 && in_valid[m_owner] && can_take) begin
      m_ov = 1;
      m_od = in_data[m_owner*8 +: 8];
      m_ol = in_last[m_owner];
      if (in_last[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end else begin
      if (m_ov && out_ready) m_ov = 0;
      if (m_owner < 0) begin
        win = -1;
        for (int k = 0; k < 4; k++)
          if (win < 0 && in_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        if (win >= 0) begin
          m_owner = win;
          m_sel   = win;
        end
      end
    end
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < 4; i++) if (pq[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (pq[i].size() != 0 && !stall[i]) begin
        in_valid[i]       = 1'b1;
        in_last[i]        = pq[i][0][8];
        in_data[i*8 +: 8] = pq[i][0][7:0];
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
      end
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic tick();
    logic [3:0] acc;
    logic [3:0] g_before;
    drive();
    #2;
    acc = in_valid & in_ready;
    if (out_valid && out_ready) got.push_back({out_last, out_data});
    g_before = grant;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) void'(pq[i].pop_front());
    if (grant != 4'b0000 && g_before == 4'b0000) gq.push_back(grant);
  endtask

  task automatic wait_drain(input int maxc, output bit ok);
    ok = 0;
    for (int c = 0; c < maxc; c++) begin
      if (queues_empty() && grant == 4'b0000 && !out_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_grant(input logic [3:0] g, input int maxc, output bit ok);
    ok = 0;
    for (int c = 0; c < maxc; c++) begin
      tick();
      if (grant == g) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) pq[i].delete();
    stall = 4'b0000;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_data = 32'h0;
    stall = 4'b0000;
    drive();
    model_reset();
    #12;
    n_checks++;
    if ({grant, sel, busy, out_valid, out_last, in_ready, out_data} !== 22'd0)
      $display("FAIL reset_outputs: got grant=%b sel=%0d busy=%b ov=%b ol=%b rdy=%b od=%h required all 0",
               grant, sel, busy, out_valid, out_last, in_ready, out_data);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_single_requester();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    out_ready = 1'b1;
    pq[2].push_back({1'b0, 8'h11});
    pq[2].push_back({1'b0, 8'h22});
    pq[2].push_back({1'b1, 8'h33});
    drive();
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) $display("FAIL single_idle_ready: got %b required 0000", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (grant !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1)
      $display("FAIL single_grant: got grant=%b sel=%0d busy=%b required 0100/2/1", grant, sel, busy);
    else n_pass++;
    for (int b = 0; b < 3; b++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== vals[b] || out_last !== (b == 2))
        $display("FAIL single_beat%0d: got v=%b d=%h l=%b required 1/%h/%b",
                 b, out_valid, out_data, out_last, vals[b], (b == 2));
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0 || grant !== 4'b0000)
      $display("FAIL single_release: got busy=%b grant=%b required 0/0000", busy, grant);
    else n_pass++;
    tick();
  endtask

  task automatic test_pointer_wrap();
    bit ok;
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b1000; exp_g[1] = 4'b0001; exp_g[2] = 4'b1000;
    gq.delete();
    pq[0].push_back({1'b1, 8'h50});
    pq[3].push_back({1'b1, 8'h53});
    pq[3].push_back({1'b1, 8'h63});
    wait_drain(100, ok);
    n_checks++;
    if (!ok || gq.size() != 3) $display("FAIL wrap_count: got %0d grants ok=%b required 3", gq.size(), ok);
    else n_pass++;
    for (int k = 0; k < 3 && k < gq.size(); k++) begin
      n_checks++;
      if (gq[k] !== exp_g[k]) $display("FAIL wrap_order%0d: got %b required %b", k, gq[k], exp_g[k]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [8:0] e;
    apply_reset();
    out_ready = 1'b1;
    gq.delete();
    got.delete();
    for (int i = 0; i < 4; i++) begin
      pq[i].push_back({1'b1, 8'hA0 + 8'(i)});
      pq[i].push_back({1'b1, 8'hA0 + 8'(i)});
    end
    wait_drain(200, ok);
    n_checks++;
    if (!ok || gq.size() != 8 || got.size() != 8)
      $display("FAIL rr_count: got grants=%0d beats=%0d ok=%b required 8/8/1", gq.size(), got.size(), ok);
    else n_pass++;
    for (int k = 0; k < 8 && k < gq.size() && k < got.size(); k++) begin
      e = {1'b1, 8'hA0 + 8'(k % 4)};
      n_checks++;
      if (gq[k] !== 4'(1 << (k % 4)) || got[k] !== e)
        $display("FAIL rr_order%0d: got grant=%b beat=%h required %b/%h", k, gq[k], got[k], 4'(1 << (k % 4)), e);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [8:0] e;
    out_ready = 1'b1;
    got.delete();
    for (int b = 0; b < 4; b++) pq[0].push_back({(b == 3), 8'hC0 + 8'(b)});
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      ok = out_valid;
    end
    n_checks++;
    if (!ok) $display("FAIL bp_first_beat: out_valid=%b required 1 within 20 cycles", out_valid);
    else n_pass++;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive();
      #1;
      n_checks++;
      if (in_ready[0] !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hC0)
        $display("FAIL bp_hold%0d: got rdy0=%b v=%b d=%h required 0/1/c0", c, in_ready[0], out_valid, out_data);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    wait_drain(100, ok);
    n_checks++;
    if (!ok || got.size() != 4) $display("FAIL bp_count: got %0d beats ok=%b required 4", got.size(), ok);
    else n_pass++;
    for (int b = 0; b < 4 && b < got.size(); b++) begin
      e = {(b == 3), 8'hC0 + 8'(b)};
      n_checks++;
      if (got[b] !== e) $display("FAIL bp_beat%0d: got %h required %h", b, got[b], e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) pq[1].push_back({(b == 3), 8'h71 + 8'(b)});
    wait_grant(4'b0010, 20, ok);
    n_checks++;
    if (!ok) $display("FAIL mid_grant: grant=%b required 0010", grant);
    else n_pass++;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant, sel, busy, out_valid, in_ready} !== 12'd0)
      $display("FAIL mid_async_reset: got grant=%b sel=%0d busy=%b ov=%b rdy=%b required all 0",
               grant, sel, busy, out_valid, in_ready);
    else n_pass++;
    apply_reset();
    gq.delete();
    pq[1].push_back({1'b1, 8'h91});
    pq[2].push_back({1'b1, 8'h92});
    tick();
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL mid_restart: got grant=%b required 0010", grant);
    else n_pass++;
    wait_drain(50, ok);
    n_checks++;
    if (!ok || gq.size() != 2) $display("FAIL mid_drain: got %0d grants ok=%b required 2", gq.size(), ok);
    else n_pass++;
  endtask

  task automatic test_stalled_owner();
    bit ok;
    logic [8:0] e [4];
    e[0] = 9'h081; e[1] = 9'h082; e[2] = 9'h183; e[3] = 9'h193;
    out_ready = 1'b1;
    got.delete();
    gq.delete();
    pq[1].push_back(9'h081);
    pq[1].push_back(9'h082);
    pq[1].push_back(9'h183);
    wait_grant(4'b0010, 20, ok);
    stall[1] = 1'b1;
    pq[3].push_back(9'h193);
    for (int c = 0; c < 5; c++) begin
      drive();
      #1;
      n_checks++;
      if (grant !== 4'b0010 || in_ready[3] !== 1'b0)
        $display("FAIL stall_hold%0d: got grant=%b rdy3=%b required 0010/0", c, grant, in_ready[3]);
      else n_pass++;
      tick();
    end
    stall[1] = 1'b0;
    wait_drain(100, ok);
    n_checks++;
    if (!ok || got.size() != 4 || gq.size() != 2 || gq[0] !== 4'b0010 || gq[1] !== 4'b1000)
      $display("FAIL stall_resume: got beats=%0d grants=%0d ok=%b required 4 beats, grants 0010 then 1000",
               got.size(), gq.size(), ok);
    else n_pass++;
    for (int b = 0; b < 4 && b < got.size(); b++) begin
      n_checks++;
      if (got[b] !== e[b]) $display("FAIL stall_beat%0d: got %h required %h", b, got[b], e[b]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ok;
    int ch, len;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch  = $urandom_range(0, 3);
        len = $urandom_range(1, 4);
        if (pq[ch].size() < 8)
          for (int b = 0; b < len; b++) pq[ch].push_back({(b == len - 1), 8'($urandom)});
      end
      for (int i = 0; i < 4; i++) stall[i] = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      drive();
      #1;
      n_checks++;
      if (in_ready !== exp_ready()) $display("FAIL rnd_ready c%0d: got %b required %b", c, in_ready, exp_ready());
      else n_pass++;
      tick();
      n_checks++;
      if (grant !== exp_grant() || sel !== 2'(m_sel) || busy !== (m_owner >= 0))
        $display("FAIL rnd_grant c%0d: got grant=%b sel=%0d busy=%b required %b/%0d/%b",
                 c, grant, sel, busy, exp_grant(), m_sel, (m_owner >= 0));
      else n_pass++;
      n_checks++;
      if (out_valid !== m_ov || out_data !== m_od || out_last !== m_ol)
        $display("FAIL rnd_out c%0d: got v=%b d=%h l=%b required %b/%h/%b",
                 c, out_valid, out_data, out_last, m_ov, m_od, m_ol);
      else n_pass++;
    end
    stall = 4'b0000;
    out_ready = 1'b1;
    wait_drain(400, ok);
    n_checks++;
    if (!ok) $display("FAIL rnd_drain: traffic did not drain, grant=%b ov=%b", grant, out_valid);
    else n_pass++;
  endtask

  initial begin
    in_valid = 4'b0000;
    in_last = 4'b0000;
    test_reset();
    test_single_requester();
    test_pointer_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid_packet();
    test_stalled_owner();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
